// File: rtl/cla15_rr_arbiter.sv
// Round-robin front end for a shared 15-bit carry-lookahead adder.
// Arbitrates N_REQ valid/ready requesters. It registers the winning operands
// (stage A), which drive the external adder. It registers the adder sum with the
// requester ID (stage B) and presents that pair on one valid/ready response channel.
// Ports:
//   i_clk, i_rst               clock, async active-high reset
//   i_req_valid/add1/add2      per-requester requests, operands packed k*WIDTH
//   o_req_ready                one-hot accept strobe (combinational)
//   o_add1/o_add2              operands to the adder (from stage A)
//   i_add_result               adder sum, carry-out in MSB
//   o_rsp_valid/id/result      response channel (stage B), i_rsp_ready from consumer
//   o_busy                     either stage holds data
//   o_done_cnt                 completed responses, wraps
module cla15_rr_arbiter #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned WIDTH = 15,
   parameter int unsigned ID_W  = 2,
   parameter int unsigned CNT_W = 16
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic [N_REQ-1:0]       i_req_valid,
   input  logic [N_REQ*WIDTH-1:0] i_req_add1,
   input  logic [N_REQ*WIDTH-1:0] i_req_add2,
   output logic [N_REQ-1:0]       o_req_ready,
   output logic [WIDTH-1:0]       o_add1,
   output logic [WIDTH-1:0]       o_add2,
   input  logic [WIDTH:0]         i_add_result,
   output logic                   o_rsp_valid,
   output logic [ID_W-1:0]        o_rsp_id,
   output logic [WIDTH:0]         o_rsp_result,
   input  logic                   i_rsp_ready,
   output logic                   o_busy,
   output logic [CNT_W-1:0]       o_done_cnt
);

   localparam int unsigned RES_W = WIDTH + 1;

   logic              op_valid_q, op_valid_d;
   logic [ID_W-1:0]   op_id_q, op_id_d;
   logic [WIDTH-1:0]  op_add1_q, op_add1_d;
   logic [WIDTH-1:0]  op_add2_q, op_add2_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
   logic [RES_W-1:0]  rsp_result_q, rsp_result_d;
   logic [CNT_W-1:0]  done_cnt_q, done_cnt_d;
   logic [ID_W-1:0]   last_grant_q, last_grant_d;

   logic              found;
   logic [ID_W-1:0]   win;
   logic [N_REQ-1:0]  vld_sh;
   logic              above;
   logic              adv_b;
   logic              can_accept;
   logic              accept;
   logic              rsp_hs;

   // Round-robin search: first pass takes indices above last_grant, second pass wraps.
   always_comb begin
      found  = 1'b0;
      win    = '0;
      vld_sh = '0;
      above  = 1'b0;
      for (int unsigned pass = 0; pass < 2; pass++) begin
         for (int unsigned k = 0; k < N_REQ; k++) begin
            vld_sh = i_req_valid >> k;
            above  = (k > 32'(last_grant_q));
            if (!found && vld_sh[0] && (above == (pass == 0))) begin
               found = 1'b1;
               win   = ID_W'(k);
            end
         end
      end
   end

   assign adv_b      = op_valid_q && (!rsp_valid_q || i_rsp_ready);
   assign can_accept = !op_valid_q || adv_b;
   // Ready is held low during reset so nothing is accepted into clearing registers.
   assign accept     = found && can_accept && !i_rst;
   assign rsp_hs     = rsp_valid_q && i_rsp_ready;

   assign o_req_ready = accept ? (N_REQ'(1) << win) : '0;

   // Next state for both pipeline stages, the grant pointer and the counter.
   always_comb begin
      op_valid_d   = op_valid_q;
      op_id_d      = op_id_q;
      op_add1_d    = op_add1_q;
      op_add2_d    = op_add2_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_id_d     = rsp_id_q;
      rsp_result_d = rsp_result_q;
      done_cnt_d   = done_cnt_q;
      last_grant_d = last_grant_q;

      if (adv_b) begin
         rsp_valid_d  = 1'b1;
         rsp_id_d     = op_id_q;
         rsp_result_d = i_add_result;
         op_valid_d   = 1'b0;
      end else if (rsp_hs) begin
         rsp_valid_d  = 1'b0;
      end

      if (accept) begin
         op_valid_d   = 1'b1;
         op_id_d      = win;
         op_add1_d    = WIDTH'(i_req_add1 >> (32'(win) * WIDTH));
         op_add2_d    = WIDTH'(i_req_add2 >> (32'(win) * WIDTH));
         last_grant_d = win;
      end

      if (rsp_hs) begin
         done_cnt_d = done_cnt_q + CNT_W'(1);
      end
   end

   // State registers; the pointer resets to the last index so requester 0 wins first.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         op_valid_q   <= 1'b0;
         op_id_q      <= '0;
         op_add1_q    <= '0;
         op_add2_q    <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= '0;
         rsp_result_q <= '0;
         done_cnt_q   <= '0;
         last_grant_q <= ID_W'(N_REQ - 1);
      end else begin
         op_valid_q   <= op_valid_d;
         op_id_q      <= op_id_d;
         op_add1_q    <= op_add1_d;
         op_add2_q    <= op_add2_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_id_q     <= rsp_id_d;
         rsp_result_q <= rsp_result_d;
         done_cnt_q   <= done_cnt_d;
         last_grant_q <= last_grant_d;
      end
   end

   assign o_add1       = op_add1_q;
   assign o_add2       = op_add2_q;
   assign o_rsp_valid  = rsp_valid_q;
   assign o_rsp_id     = rsp_id_q;
   assign o_rsp_result = rsp_result_q;
   assign o_done_cnt   = done_cnt_q;
   assign o_busy       = op_valid_q || rsp_valid_q;

endmodule

// File: tb/tb_cla15_rr_arbiter.sv
// Directed bench for cla15_rr_arbiter with a behavioural stand-in for cla_15bit.
module tb_cla15_rr_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  req_valid = '0;
   logic [59:0] req_add1 = '0;
   logic [59:0] req_add2 = '0;
   logic [3:0]  req_ready;
   logic [14:0] add1, add2;
   logic [15:0] add_result;
   logic        rsp_valid;
   logic [1:0]  rsp_id;
   logic [15:0] rsp_result;
   logic        rsp_ready = 1'b0;
   logic        busy;
   logic [15:0] done_cnt;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   // External adder model: zero-extended sum, no carry-in.
   assign add_result = 16'(add1) + 16'(add2);

   cla15_rr_arbiter #(.N_REQ(4), .WIDTH(15), .ID_W(2), .CNT_W(16)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_req_valid(req_valid), .i_req_add1(req_add1), .i_req_add2(req_add2),
      .o_req_ready(req_ready), .o_add1(add1), .o_add2(add2),
      .i_add_result(add_result),
      .o_rsp_valid(rsp_valid), .o_rsp_id(rsp_id), .o_rsp_result(rsp_result),
      .i_rsp_ready(rsp_ready), .o_busy(busy), .o_done_cnt(done_cnt)
   );

   typedef struct {
      logic        do_rst;
      logic [3:0]  valid;
      logic [59:0] a1;
      logic [59:0] a2;
      logic        rrdy;
      logic [3:0]  exp_ready;
      logic        exp_rv;
      logic [1:0]  exp_id;
      logic [15:0] exp_res;
      logic [15:0] exp_done;
   } vec_t;

   vec_t vecs[$];

   function automatic logic [59:0] pk(input int a3, input int a2, input int a1, input int a0);
      return {15'(a3), 15'(a2), 15'(a1), 15'(a0)};
   endfunction

   function automatic vec_t mk(input logic r, input logic [3:0] v, input logic [59:0] a1,
                               input logic [59:0] a2, input logic rr, input logic [3:0] er,
                               input logic erv, input logic [1:0] eid, input logic [15:0] eres,
                               input logic [15:0] edone);
      vec_t t;
      t.do_rst = r; t.valid = v; t.a1 = a1; t.a2 = a2; t.rrdy = rr;
      t.exp_ready = er; t.exp_rv = erv; t.exp_id = eid; t.exp_res = eres; t.exp_done = edone;
      return t;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; req_valid = '0; rsp_ready = 1'b0; req_add1 = '0; req_add2 = '0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      logic [59:0] t1, t2, t3;
      logic [59:0] z;
      int n;
      bit acc;
      bit hit;
      z = '0;
      t1 = pk(3, 2, 1, 0);
      t2 = pk(16'h100, 0, 0, 5);
      t3 = pk(16'h23, 0, 0, 6);

      // Test 1: single op with carry into MSB.
      vecs.push_back(mk(1, 4'b0001, pk(0,0,0,16'h7FFF), pk(0,0,0,1), 1, 4'b0001, 0, 0, 16'h0000, 0));
      vecs.push_back(mk(0, 4'b0000, z, z, 1, 4'b0000, 1, 0, 16'h8000, 0));
      vecs.push_back(mk(0, 4'b0000, z, z, 1, 4'b0000, 0, 0, 16'h8000, 1));
      // Test 2: all valid, operands k+k, back-to-back rotation.
      vecs.push_back(mk(1, 4'b1111, t1, t1, 1, 4'b0001, 0, 0, 16'h0000, 0));
      vecs.push_back(mk(0, 4'b1111, t1, t1, 1, 4'b0010, 1, 0, 16'h0000, 0));
      vecs.push_back(mk(0, 4'b1111, t1, t1, 1, 4'b0100, 1, 1, 16'h0002, 1));
      vecs.push_back(mk(0, 4'b1111, t1, t1, 1, 4'b1000, 1, 2, 16'h0004, 2));
      vecs.push_back(mk(0, 4'b1111, t1, t1, 1, 4'b0001, 1, 3, 16'h0006, 3));
      vecs.push_back(mk(0, 4'b0000, z, z, 1, 4'b0000, 1, 0, 16'h0000, 4));
      vecs.push_back(mk(0, 4'b0000, z, z, 1, 4'b0000, 0, 0, 16'h0000, 5));
      // Test 3: requesters 0 and 3 alternate.
      vecs.push_back(mk(1, 4'b1001, t2, t3, 1, 4'b0001, 0, 0, 16'h0000, 0));
      vecs.push_back(mk(0, 4'b1001, t2, t3, 1, 4'b1000, 1, 0, 16'h000B, 0));
      vecs.push_back(mk(0, 4'b1001, t2, t3, 1, 4'b0001, 1, 3, 16'h0123, 1));
      vecs.push_back(mk(0, 4'b1001, t2, t3, 1, 4'b1000, 1, 0, 16'h000B, 2));
      vecs.push_back(mk(0, 4'b0000, z, z, 1, 4'b0000, 1, 3, 16'h0123, 3));
      vecs.push_back(mk(0, 4'b0000, z, z, 1, 4'b0000, 0, 3, 16'h0123, 4));

      // Reset state while reset is held.
      req_valid = 4'b0001;
      #2;
      check("rst_ready", 32'(req_ready), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_rsp_valid", 32'(rsp_valid), 0);
      check("rst_done", 32'(done_cnt), 0);
      check("rst_add1", 32'(add1), 0);
      check("rst_result", 32'(rsp_result), 0);
      req_valid = '0;

      foreach (vecs[i]) begin
         if (vecs[i].do_rst) do_reset();
         @(negedge clk);
         req_valid = vecs[i].valid; req_add1 = vecs[i].a1; req_add2 = vecs[i].a2;
         rsp_ready = vecs[i].rrdy;
         #1;
         check($sformatf("v%0d_ready", i), 32'(req_ready), 32'(vecs[i].exp_ready));
         @(posedge clk);
         #1;
         check($sformatf("v%0d_rsp_valid", i), 32'(rsp_valid), 32'(vecs[i].exp_rv));
         check($sformatf("v%0d_rsp_id", i), 32'(rsp_id), 32'(vecs[i].exp_id));
         check($sformatf("v%0d_rsp_result", i), 32'(rsp_result), 32'(vecs[i].exp_res));
         check($sformatf("v%0d_done", i), 32'(done_cnt), 32'(vecs[i].exp_done));
      end

      // Test 4: backpressure on a requester-1 stream; operands 100+n, n.
      do_reset();
      n = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         rsp_ready = 1'b0; req_valid = 4'b0010;
         req_add1 = 60'(100 + n) << 15; req_add2 = 60'(n) << 15;
         #1;
         check($sformatf("bp%0d_ready", c), 32'(req_ready), (c < 2) ? 32'h2 : 32'h0);
         acc = req_ready[1];
         @(posedge clk);
         #1;
         if (acc) n++;
         if (c >= 1) begin
            check($sformatf("bp%0d_rsp_valid", c), 32'(rsp_valid), 1);
            check($sformatf("bp%0d_rsp_result", c), 32'(rsp_result), 100);
            check($sformatf("bp%0d_rsp_id", c), 32'(rsp_id), 1);
         end
      end
      @(negedge clk);
      req_valid = '0; rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp_rel1_valid", 32'(rsp_valid), 1);
      check("bp_rel1_result", 32'(rsp_result), 102);
      check("bp_rel1_done", 32'(done_cnt), 1);
      @(posedge clk);
      #1;
      check("bp_rel2_valid", 32'(rsp_valid), 0);
      check("bp_rel2_done", 32'(done_cnt), 2);
      check("bp_rel2_busy", 32'(busy), 0);

      // Test 5: async reset with both stages full.
      do_reset();
      @(negedge clk);
      req_valid = 4'b0001; req_add1 = pk(0,0,0,1); req_add2 = pk(0,0,0,1); rsp_ready = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      req_valid = '0; rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 4'b0001; rsp_ready = 1'b0;
      @(posedge clk);
      #1;
      check("ar_pre_busy", 32'(busy), 1);
      check("ar_pre_done", 32'(done_cnt), 1);
      check("ar_pre_valid", 32'(rsp_valid), 1);
      #2;
      rst = 1'b1;
      #1;
      check("ar_rsp_valid", 32'(rsp_valid), 0);
      check("ar_busy", 32'(busy), 0);
      check("ar_done", 32'(done_cnt), 0);
      check("ar_ready", 32'(req_ready), 0);
      @(negedge clk);
      rst = 1'b0;
      req_valid = 4'b0101; req_add1 = pk(0,16'h22,0,16'h11); req_add2 = '0;
      #1;
      check("ar_grant0", 32'(req_ready), 32'h1);
      @(posedge clk);
      #1;
      check("ar_add1", 32'(add1), 32'h11);
      @(negedge clk);
      req_valid = '0;

      // Test 6: counter wrap with a max-operand sum.
      do_reset();
      hit = 1'b0;
      for (int c = 0; c < 70000; c++) begin
         @(negedge clk);
         req_valid = 4'b0001; req_add1 = pk(0,0,0,16'h7FFF); req_add2 = pk(0,0,0,16'h7FFF);
         rsp_ready = 1'b1;
         @(posedge clk);
         #1;
         if (done_cnt == 16'hFFFF) begin
            hit = 1'b1;
            break;
         end
      end
      check("wrap_reached", 32'(hit), 1);
      @(negedge clk);
      req_valid = '0;
      #1;
      check("wrap_rsp_valid", 32'(rsp_valid), 1);
      check("wrap_result", 32'(rsp_result), 32'hFFFE);
      @(posedge clk);
      #1;
      check("wrap_done", 32'(done_cnt), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/cla15_rr_arbiter.md
Name: cla15_rr_arbiter

Overview:
- Shares one combinational 15-bit carry-lookahead adder (cla_15bit: 15-bit operands, 16-bit sum, carry-in tied low) among N_REQ requesters.
- Round-robin arbitration with per-requester valid/ready handshakes.
- Registers the granted operands in front of the adder and the sum behind it.
- Returns each result with a requester ID on one shared valid/ready response channel.
- Sits between client blocks and the adder instance; the adder is instantiated outside this block.

Parameters:
N_REQ, 4, number of requesters (2..8)
WIDTH, 15, operand width; must equal the adder's operand width
ID_W, 2, requester ID width; must be at least clog2(N_REQ)
CNT_W, 16, width of completed-operation counter

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  reset, asynchronous, active-high
i_req_valid  in  N_REQ  per-requester operation valid
i_req_add1  in  N_REQ*WIDTH  operand 1, requester k at bits [k*WIDTH +: WIDTH]
i_req_add2  in  N_REQ*WIDTH  operand 2, same packing
o_req_ready  out  N_REQ  one-hot (or zero) accept strobe
o_add1  out  WIDTH  to adder i_add1
o_add2  out  WIDTH  to adder i_add2
i_add_result  in  WIDTH+1  from adder o_result
o_rsp_valid  out  1  response valid
o_rsp_id  out  ID_W  requester index of response
o_rsp_result  out  WIDTH+1  sum including carry-out in MSB
i_rsp_ready  in  1  response consumer ready
o_busy  out  1  op stage or response stage holds valid data
o_done_cnt  out  CNT_W  completed responses, wraps

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. While i_rst is high, all registers clear immediately: op_valid=0, op_id=0, op operands=0, o_rsp_valid=0, o_rsp_id=0, o_rsp_result=0, o_done_cnt=0, last_grant=N_REQ-1 (requester 0 has first priority). Combinational outputs follow: o_req_ready=0 (both stages empty but no registered grant bias beyond pointer; ready is allowed once i_rst is deasserted), o_add1=o_add2=0, o_busy=0.
- Reset mid-operation: in-flight operation and held response are discarded; no response is produced for them.
- Stage A (operand register): op_valid, op_id, op_add1, op_add2. o_add1/o_add2 are driven directly from op_add1/op_add2. The adder path is purely combinational.
- Stage B (response register): o_rsp_valid, o_rsp_id, o_rsp_result.
- Advance conditions:
  - adv_b = op_valid && (!o_rsp_valid || i_rsp_ready)
  - can_accept = !op_valid || adv_b
- Arbitration:
  - Search i_req_valid starting at index last_grant+1, modulo N_REQ; the first asserted index is the winner w.
  - o_req_ready[w] = can_accept; all other bits are 0. If no valid is asserted, o_req_ready=0.
  - ready depends combinationally on valid, so requesters must not gate valid on ready.
  - A requester, once its valid is asserted, holds valid and operands stable until accepted.
- Accept edge (valid && ready for w): op regs load requester w's operands, op_id=w, op_valid=1, last_grant=w. The pointer updates only on an accept.
- At an edge with adv_b: o_rsp_result=i_add_result, o_rsp_id=op_id, o_rsp_valid=1. op_valid clears unless a new accept happens in the same edge.
- At an edge with o_rsp_valid && i_rsp_ready && !adv_b: o_rsp_valid=0.
- o_done_cnt increments by 1 on each edge with o_rsp_valid && i_rsp_ready, and wraps from all-ones to 0.
- Latency: accept edge at T gives o_rsp_valid high after edge T+1 if stage B is free. Throughput is 1 op/cycle with i_rsp_ready held high.
- Backpressure: while o_rsp_valid && !i_rsp_ready, stage B holds stable and stage A holds stable. At most 2 ops are buffered; o_req_ready stays all 0 once stage A is full.
- Simultaneous drain and fill: response handshake, stage A to B transfer, and new accept all occur in one edge with no bubble.
- Arithmetic: no carry-in. Result is the zero-extended WIDTH+1-bit sum from the adder, unmodified.
- o_busy = op_valid || o_rsp_valid.

Test Plan:
1. Single op: requester 0 sends 15'h7FFF + 15'h0001, i_rsp_ready=1 -> o_req_ready=4'b0001 for one cycle; o_rsp_valid high after the next edge with o_rsp_result=16'h8000, o_rsp_id=0; o_done_cnt=1.
2. All four valid continuously, each with operands k and k, i_rsp_ready=1 -> accept order 0,1,2,3,0,1...; one response per cycle with results 16'h0000, 2, 4, 6 in order; no bubbles.
3. Requesters 0 and 3 valid, last_grant=0 -> next grant 3, then 0, alternating; requester 0 is never granted twice in a row while 3 is waiting.
4. Backpressure: stream on requester 1, i_rsp_ready=0 for 5 cycles -> exactly 2 accepts, then o_req_ready=0. o_rsp_result and o_rsp_id stay stable. After release, responses continue in order with none lost or duplicated.
5. Assert i_rst asynchronously (between edges) with both stages full -> o_rsp_valid, o_busy and o_done_cnt go to 0 immediately. After deassertion, with requesters 0 and 2 valid, requester 0 is granted first.
6. Preload 65535 completions, then 1 more -> o_done_cnt wraps 16'hFFFF to 16'h0000; 15'h7FFF + 15'h7FFF returns 16'hFFFE.
